// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX boundary: control bundle layout,
// the all-zero bubble value, ALU operation classes and bubble classification.
package id_ex_stage_pkg;

  // ALU operation classes produced by the main decoder.
  typedef enum logic [2:0] {
    ALU_OP_ADD    = 3'd0,  // address generation for loads/stores
    ALU_OP_BRANCH = 3'd1,  // compare for conditional branches
    ALU_OP_RTYPE  = 3'd2,  // register-register, funct3/funct7 select
    ALU_OP_ITYPE  = 3'd3,  // register-immediate, funct3 selects
    ALU_OP_LUI    = 3'd4,  // pass immediate
    ALU_OP_AUIPC  = 3'd5,  // pc + immediate
    ALU_OP_JUMP   = 3'd6   // link address pc + 4
  } alu_op_e;

  // Control bundle carried from ID into EX.
  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       jal;
    logic       jalr;
    logic       alu_src;
    alu_op_e    alu_op;
    logic [2:0] funct3;
    logic       funct7b5;
  } ctrl_t;

  // A bubble has no side effects anywhere downstream.
  localparam ctrl_t BUBBLE = '0;

  // True when the entry captured on this edge is a bubble: either a flush
  // forces one in, or ID is not stalled and offers no real instruction.
  function automatic logic bubble_capture(input logic flush,
                                          input logic stall,
                                          input logic valid);
    return flush | (~stall & ~valid);
  endfunction

endpackage

// File: rtl/id_ex_stage_bubble_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module bubble_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Next count: clear first, then increment unless already at all-ones.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != '1)) begin
      count_next = count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Counter state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the (possibly zeroed) control bundle and
// decode operands, handles stall/flush, detects load-use hazards and counts
// inserted bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic                  branch_in,
  input  logic                  mem_read_in,
  input  logic                  mem_to_reg_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic                  jal_in,
  input  logic                  jalr_in,
  input  logic                  alu_src_in,
  input  logic [2:0]            alu_op_in,
  input  logic [2:0]            funct3_in,
  input  logic                  funct7b5_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] rs1_data_in,
  input  logic [DATA_WIDTH-1:0] rs2_data_in,
  input  logic [DATA_WIDTH-1:0] imm_in,
  input  logic [REG_ADDR-1:0]   rs1_in,
  input  logic [REG_ADDR-1:0]   rs2_in,
  input  logic [REG_ADDR-1:0]   rd_in,
  input  logic                  clr_cnt_in,
  output logic                  branch_out,
  output logic                  mem_read_out,
  output logic                  mem_to_reg_out,
  output logic                  mem_write_out,
  output logic                  reg_write_out,
  output logic                  jal_out,
  output logic                  jalr_out,
  output logic                  alu_src_out,
  output logic [2:0]            alu_op_out,
  output logic [2:0]            funct3_out,
  output logic                  funct7b5_out,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] rs1_data_out,
  output logic [DATA_WIDTH-1:0] rs2_data_out,
  output logic [DATA_WIDTH-1:0] imm_out,
  output logic [REG_ADDR-1:0]   rs1_out,
  output logic [REG_ADDR-1:0]   rs2_out,
  output logic [REG_ADDR-1:0]   rd_out,
  output logic                  valid_out,
  output logic                  hazard_out,
  output logic [CNT_WIDTH-1:0]  bubble_cnt_out
);

  ctrl_t ctrl_in;
  ctrl_t ctrl_reg, ctrl_next;
  logic                  valid_reg, valid_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] rs1_data_reg, rs1_data_next;
  logic [DATA_WIDTH-1:0] rs2_data_reg, rs2_data_next;
  logic [DATA_WIDTH-1:0] imm_reg, imm_next;
  logic [REG_ADDR-1:0]   rs1_reg, rs1_next;
  logic [REG_ADDR-1:0]   rs2_reg, rs2_next;
  logic [REG_ADDR-1:0]   rd_reg, rd_next;
  logic                  bubble_inc;

  assign ctrl_in = '{
    branch:     branch_in,
    mem_read:   mem_read_in,
    mem_to_reg: mem_to_reg_in,
    mem_write:  mem_write_in,
    reg_write:  reg_write_in,
    jal:        jal_in,
    jalr:       jalr_in,
    alu_src:    alu_src_in,
    alu_op:     alu_op_e'(alu_op_in),
    funct3:     funct3_in,
    funct7b5:   funct7b5_in
  };

  // Next-entry select: flush inserts an all-zero bubble, stall holds,
  // otherwise load; an invalid ID slot is captured with bubble control.
  always_comb begin
    ctrl_next     = ctrl_reg;
    valid_next    = valid_reg;
    pc_next       = pc_reg;
    rs1_data_next = rs1_data_reg;
    rs2_data_next = rs2_data_reg;
    imm_next      = imm_reg;
    rs1_next      = rs1_reg;
    rs2_next      = rs2_reg;
    rd_next       = rd_reg;
    if (flush_in) begin
      ctrl_next     = BUBBLE;
      valid_next    = 1'b0;
      pc_next       = '0;
      rs1_data_next = '0;
      rs2_data_next = '0;
      imm_next      = '0;
      rs1_next      = '0;
      rs2_next      = '0;
      rd_next       = '0;
    end else if (!stall_in) begin
      ctrl_next     = valid_in ? ctrl_in : BUBBLE;
      valid_next    = valid_in;
      pc_next       = pc_in;
      rs1_data_next = rs1_data_in;
      rs2_data_next = rs2_data_in;
      imm_next      = imm_in;
      rs1_next      = rs1_in;
      rs2_next      = rs2_in;
      rd_next       = rd_in;
    end
  end

  // EX-side pipeline register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_reg     <= BUBBLE;
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
    end else begin
      ctrl_reg     <= ctrl_next;
      valid_reg    <= valid_next;
      pc_reg       <= pc_next;
      rs1_data_reg <= rs1_data_next;
      rs2_data_reg <= rs2_data_next;
      imm_reg      <= imm_next;
      rs1_reg      <= rs1_next;
      rs2_reg      <= rs2_next;
      rd_reg       <= rd_next;
    end
  end

  // Load-use: a load in EX whose destination is read by the instruction in
  // ID. x0 is never a real dependency. Independent of stall/flush so the
  // hazard unit sees the raw request.
  assign hazard_out = valid_reg & ctrl_reg.mem_read & (rd_reg != '0) &
                      ((rd_reg == rs1_in) | (rd_reg == rs2_in));

  assign bubble_inc = bubble_capture(flush_in, stall_in, valid_in);

  bubble_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_bubble_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt_in),
    .inc   (bubble_inc),
    .count (bubble_cnt_out)
  );

  assign branch_out     = ctrl_reg.branch;
  assign mem_read_out   = ctrl_reg.mem_read;
  assign mem_to_reg_out = ctrl_reg.mem_to_reg;
  assign mem_write_out  = ctrl_reg.mem_write;
  assign reg_write_out  = ctrl_reg.reg_write;
  assign jal_out        = ctrl_reg.jal;
  assign jalr_out       = ctrl_reg.jalr;
  assign alu_src_out    = ctrl_reg.alu_src;
  assign alu_op_out     = ctrl_reg.alu_op;
  assign funct3_out     = ctrl_reg.funct3;
  assign funct7b5_out   = ctrl_reg.funct7b5;
  assign valid_out      = valid_reg;
  assign pc_out         = pc_reg;
  assign rs1_data_out   = rs1_data_reg;
  assign rs2_data_out   = rs2_data_reg;
  assign imm_out        = imm_reg;
  assign rs1_out        = rs1_reg;
  assign rs2_out        = rs2_reg;
  assign rd_out         = rd_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the pipeline slot.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // Control vector bit positions (tb-side packing only).
  localparam int B_MEM_READ  = 13;
  localparam int B_MEM_WRITE = 11;
  localparam int B_REG_WRITE = 10;

  logic clk = 1'b0;
  logic reset;
  logic stall_in, flush_in, valid_in, clr_cnt_in;
  logic [14:0] c_in;
  logic branch_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in;
  logic jal_in, jalr_in, alu_src_in, funct7b5_in;
  logic [2:0] alu_op_in, funct3_in;
  logic [DW-1:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
  logic [RW-1:0] rs1_in, rs2_in, rd_in;
  logic branch_out, mem_read_out, mem_to_reg_out, mem_write_out, reg_write_out;
  logic jal_out, jalr_out, alu_src_out, funct7b5_out;
  logic [2:0] alu_op_out, funct3_out;
  logic [DW-1:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [RW-1:0] rs1_out, rs2_out, rd_out;
  logic valid_out, hazard_out;
  logic [CW-1:0] bubble_cnt_out;
  logic [14:0] c_out;

  assign {branch_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in,
          jal_in, jalr_in, alu_src_in, alu_op_in, funct3_in, funct7b5_in} = c_in;
  assign c_out = {branch_out, mem_read_out, mem_to_reg_out, mem_write_out,
                  reg_write_out, jal_out, jalr_out, alu_src_out, alu_op_out,
                  funct3_out, funct7b5_out};

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .jal_in(jal_in), .jalr_in(jalr_in),
    .alu_src_in(alu_src_in), .alu_op_in(alu_op_in), .funct3_in(funct3_in),
    .funct7b5_in(funct7b5_in), .pc_in(pc_in), .rs1_data_in(rs1_data_in),
    .rs2_data_in(rs2_data_in), .imm_in(imm_in), .rs1_in(rs1_in),
    .rs2_in(rs2_in), .rd_in(rd_in), .clr_cnt_in(clr_cnt_in),
    .branch_out(branch_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .reg_write_out(reg_write_out), .jal_out(jal_out), .jalr_out(jalr_out),
    .alu_src_out(alu_src_out), .alu_op_out(alu_op_out),
    .funct3_out(funct3_out), .funct7b5_out(funct7b5_out), .pc_out(pc_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .imm_out(imm_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .valid_out(valid_out), .hazard_out(hazard_out),
    .bubble_cnt_out(bubble_cnt_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the EX slot contents.
  logic          m_valid;
  logic [14:0]   m_ctrl;
  logic [DW-1:0] m_pc, m_d1, m_d2, m_imm;
  logic [RW-1:0] m_rs1, m_rs2, m_rd;
  int            m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_cnt = 0;
  endtask

  // What one rising edge does to the slot, from the stage's rules.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else begin
      if (flush_in) begin
        m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_d1 = '0; m_d2 = '0;
        m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_cnt = m_cnt + 1;
      end else if (!stall_in) begin
        m_valid = valid_in;
        m_ctrl  = valid_in ? c_in : 15'd0;
        m_pc = pc_in; m_d1 = rs1_data_in; m_d2 = rs2_data_in; m_imm = imm_in;
        m_rs1 = rs1_in; m_rs2 = rs2_in; m_rd = rd_in;
        if (!valid_in) m_cnt = m_cnt + 1;
      end
      if (clr_cnt_in) m_cnt = 0;
      else if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
    end
  endtask

  function automatic logic exp_hazard();
    return m_valid && m_ctrl[B_MEM_READ] && (m_rd != 0) &&
           ((m_rd == rs1_in) || (m_rd == rs2_in));
  endfunction

  task automatic check_all();
    chk("valid", 32'(valid_out), 32'(m_valid));
    chk("ctrl", 32'(c_out), 32'(m_ctrl));
    chk("pc", pc_out, m_pc);
    chk("rs1_data", rs1_data_out, m_d1);
    chk("rs2_data", rs2_data_out, m_d2);
    chk("imm", imm_out, m_imm);
    chk("rs1", 32'(rs1_out), 32'(m_rs1));
    chk("rs2", 32'(rs2_out), 32'(m_rs2));
    chk("rd", 32'(rd_out), 32'(m_rd));
    chk("bubble_cnt", 32'(bubble_cnt_out), 32'(m_cnt));
    chk("hazard", 32'(hazard_out), 32'(exp_hazard()));
  endtask

  // One clock: check live hazard, take the edge, check registered state.
  task automatic cycle();
    #1;
    chk("hazard_pre", 32'(hazard_out), 32'(exp_hazard()));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    stall_in = 0; flush_in = 0; valid_in = 0; clr_cnt_in = 0; c_in = '0;
    pc_in = '0; rs1_data_in = '0; rs2_data_in = '0; imm_in = '0;
    rs1_in = '0; rs2_in = '0; rd_in = '0;
  endtask

  function automatic logic [RW-1:0] rand_idx();
    return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
  endfunction

  task automatic rand_inputs();
    c_in = 15'($urandom);
    valid_in = ($urandom_range(0, 3) != 0);
    stall_in = ($urandom_range(0, 4) == 0);
    flush_in = ($urandom_range(0, 7) == 0);
    clr_cnt_in = ($urandom_range(0, 24) == 0);
    pc_in = $urandom; rs1_data_in = $urandom; rs2_data_in = $urandom;
    imm_in = $urandom;
    rs1_in = rand_idx(); rs2_in = rand_idx(); rd_in = rand_idx();
  endtask

  int saved_cnt;

  initial begin
    model_reset();
    // Reset held low with random inputs: everything stays zero.
    reset = 1'b0;
    rand_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      rand_inputs();
    end

    // Release reset and load a reg-writing instruction to rd=5.
    idle();
    reset = 1'b1;
    valid_in = 1; c_in[B_REG_WRITE] = 1; rd_in = 5;
    cycle();
    chk("post_reset_valid", 32'(valid_out), 32'd1);
    chk("post_reset_rd", 32'(rd_out), 32'd5);

    // Load-use on rs1 and rs2, then an x0 destination.
    idle(); valid_in = 1; c_in[B_MEM_READ] = 1; rd_in = 7;
    cycle();
    idle(); rs1_in = 7;
    #1 chk("lu_rs1", 32'(hazard_out), 32'd1);
    rs1_in = 0; rs2_in = 7;
    #1 chk("lu_rs2", 32'(hazard_out), 32'd1);
    idle(); valid_in = 1; c_in[B_MEM_READ] = 1; rd_in = 0;
    cycle();
    rs1_in = 0;
    #1 chk("lu_x0", 32'(hazard_out), 32'd0);

    // Stall holds contents and does not count.
    idle(); valid_in = 1; pc_in = 32'h100;
    cycle();
    saved_cnt = m_cnt;
    stall_in = 1; pc_in = 32'h200;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_pc", pc_out, 32'h100);
    chk("stall_cnt", 32'(bubble_cnt_out), 32'(saved_cnt));
    stall_in = 0;
    cycle();
    chk("unstall_pc", pc_out, 32'h200);

    // Flush beats stall and inserts a fully zero bubble.
    saved_cnt = m_cnt;
    idle(); stall_in = 1; flush_in = 1; valid_in = 1; c_in[B_MEM_WRITE] = 1;
    pc_in = 32'hdead_beef; imm_in = 32'h1234;
    cycle();
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_mem_write", 32'(mem_write_out), 32'd0);
    chk("flush_pc", pc_out, 32'd0);
    chk("flush_cnt", 32'(bubble_cnt_out), 32'(saved_cnt + 1));

    // Saturation after many flushes, then clear wins over increment.
    idle(); flush_in = 1;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_cnt", 32'(bubble_cnt_out), 32'd15);
    clr_cnt_in = 1;
    cycle();
    chk("clr_cnt", 32'(bubble_cnt_out), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // Asynchronous reset between edges drops valid and hazard immediately.
    idle(); valid_in = 1; c_in[B_MEM_READ] = 1; rd_in = 7;
    cycle();
    idle(); rs1_in = 7;
    #1;
    chk("pre_areset_valid", 32'(valid_out), 32'd1);
    chk("pre_areset_hazard", 32'(hazard_out), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("areset_valid", 32'(valid_out), 32'd0);
    chk("areset_hazard", 32'(hazard_out), 32'd0);
    check_all();
    reset = 1'b1;
    valid_in = 1; c_in[B_REG_WRITE] = 1; rd_in = 9; pc_in = 32'h40;
    cycle();
    for (int i = 0; i < 30; i++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the hazard control-zeroing mux; captures the (possibly zeroed) control bundle plus decode operands and presents them to EX.
- Also owns load-use detection: compares the instruction held in EX against the source registers currently in ID and drives the `hazard_out` request that zeroes control upstream.
- Handles stall (hold), flush (bubble insert) and counts inserted bubbles for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of pc, rs1_data, rs2_data, imm
- REG_ADDR, 5, register index width
- CNT_WIDTH, 16, bubble counter width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- stall_in  input  1  hold current contents (ID stalled)
- flush_in  input  1  replace next entry with bubble (taken branch/jump)
- valid_in  input  1  ID holds a real instruction
- branch_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in, jal_in, jalr_in, alu_src_in  input  1 each  control bundle from zeroing mux
- alu_op_in  input  3  ALU operation class
- funct3_in  input  3  instruction funct3
- funct7b5_in  input  1  instruction bit 30
- pc_in, rs1_data_in, rs2_data_in, imm_in  input  DATA_WIDTH  decode operands
- rs1_in, rs2_in, rd_in  input  REG_ADDR  register indices of ID instruction
- clr_cnt_in  input  1  synchronous clear of bubble counter
- all *_out counterparts of the above  output  same widths  registered EX-side values
- valid_out  output  1  EX holds a real instruction
- hazard_out  output  1  load-use stall request to hazard unit (combinational)
- bubble_cnt_out  output  CNT_WIDTH  saturating bubble count

Behaviour:
- Reset (reset=0, asynchronous): every registered output, including valid_out and bubble_cnt_out, is 0; hazard_out therefore 0.
- Per-cycle update priority on rising clk: flush_in > stall_in > load.
- Flush: all control bits, alu_op, valid_out are cleared. Data, index and funct fields are cleared as well, so the bubble is fully zero.
- Stall (no flush): all registers hold, including valid_out.
- Load: every *_out takes its *_in value; valid_out <= valid_in. Latency is exactly 1 cycle.
- Bubble capture: any load with valid_in=0 stores zero control regardless of control inputs.
- hazard_out = valid_out & mem_read_out & (rd_out != 0) & ((rd_out == rs1_in) | (rd_out == rs2_in)).
  - Purely combinational from registered EX state and live ID indices; no register stage.
  - Evaluated independently of stall_in and flush_in.
- Bubble counter: increments by 1 on each clock where the captured entry is a bubble, i.e. flush_in=1, or (stall_in=0 and valid_in=0). Stall cycles do not count.
- Counter saturates at all-ones and never wraps.
- clr_cnt_in=1 forces the counter to 0 that clock; clear wins over a simultaneous increment.
- Reset mid-operation: immediate clear of all state; the first post-reset edge behaves as a normal load/flush/stall.
- x0 handling: rd_out=0 never raises hazard_out, even with mem_read_out=1.

Decomposition:
- Shared pipeline package holds:
  - the control-bundle struct (8 control bits + alu_op + funct3 + funct7b5)
  - a BUBBLE constant of that struct (all zero)
  - ALU_OP encodings
- One natural sub-module: `bubble_counter` (saturating counter with sync clear and increment enable).

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, load valid_in=1, reg_write_in=1, rd_in=5 -> next edge valid_out=1, reg_write_out=1, rd_out=5.
- Load-use: load lw (mem_read_in=1, rd_in=7); next cycle rs1_in=7 -> hazard_out=1. Same cycle with rs2_in=7 also 1. With rd_in=0 and rs1_in=0 -> hazard_out=0.
- Stall hold: load pc_in=0x100, then stall_in=1 for 3 cycles with pc_in=0x200 -> pc_out stays 0x100 and bubble_cnt unchanged. Release -> pc_out=0x200.
- Flush priority: stall_in=1 and flush_in=1 with valid_in=1, mem_write_in=1 -> next edge valid_out=0, mem_write_out=0, all data outputs 0, bubble_cnt increments by 1.
- Counter saturation/clear: CNT_WIDTH=4, 20 consecutive flushes -> bubble_cnt_out=15. Assert clr_cnt_in together with flush_in -> 0 next edge.
- Async reset mid-stream: assert reset between clock edges while valid_out=1 and hazard_out=1 -> both drop to 0 immediately, without waiting for a clock edge.
